// File: rtl/sequential_16bit_en.sv
// -----------------------------------------------------------------------------
// sequential_16bit_en
//
// This is the golden reference for the sequential/enable demo. It is a 16-bit
// up-counter with a synchronous count enable and an asynchronous clear. Every
// signal enters and leaves through the 28-bit user I/O bank, so a fabric
// implementation can be compared against it pad for pad.
//
// Ports:
//   clk          design clock; all state updates happen on its rising edge
//   io_in[0]     rst: asynchronous, active-high clear of the counter
//   io_in[1]     en : count enable, active-high, sampled on rising clk
//   io_in[27:2]  unused
//   io_out[1:0]  tied 0 (these pads are inputs)
//   io_out[17:2] counter value
//   io_out[18]   terminal-count flag, high while the counter reads 0xFFFF
//   io_out[27:19] tied 0
//   io_oeb       constant 28'h0000003: pads [1:0] are inputs, [27:2] are driven
// -----------------------------------------------------------------------------
module sequential_16bit_en (
  input  logic        clk,
  input  logic [27:0] io_in,
  output logic [27:0] io_out,
  output logic [27:0] io_oeb
);

  localparam int unsigned DATA_W = 16;

  logic              rst;
  logic              en;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] count_d;
  logic              tc;
  logic              unused_io_in;

  assign rst = io_in[0];
  assign en  = io_in[1];

  // The upper input pads carry nothing for this design.
  assign unused_io_in = ^io_in[27:2];

  // Modulo-2^16 increment; 0xFFFF rolls over to 0x0000 with no stall.
  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] v);
    return v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap_inc(count_q);
    end
  end

  // ---- stage p0: counter register (cleared asynchronously by rst) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // ---- output mapping: purely combinational from count_q ----
  // tc has zero latency relative to the counter, so it is decoded here rather
  // than registered.
  assign tc = (count_q == {DATA_W{1'b1}});

  assign io_out = {9'b0, tc, count_q, 2'b00};

  // Pad directions never change, including during reset.
  assign io_oeb = 28'h0000003;

endmodule

// File: tb/tb_sequential_16bit_en.sv
// -----------------------------------------------------------------------------
// Testbench for sequential_16bit_en. Stimulus pushes the expected io_out for
// the next falling edge into a queue. A separate monitor pops and compares on
// every falling edge that has a pending expectation.
// -----------------------------------------------------------------------------
module tb_sequential_16bit_en;

  logic        clk;
  logic [27:0] io_in;
  logic [27:0] io_out;
  logic [27:0] io_oeb;

  int checks;
  int errors;

  typedef struct {
    logic [27:0] out;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  sequential_16bit_en dut (
    .clk    (clk),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compose the required pad image for a given counter value.
  function automatic logic [27:0] pads_for(input logic [15:0] cnt);
    logic tc;
    tc = (cnt == 16'hFFFF);
    return {9'b0, tc, cnt, 2'b00};
  endfunction

  task automatic check(input string name, input logic [27:0] act,
                       input logic [27:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle's inputs, let the rising edge sample them, and optionally
  // queue the expected counter value for the following falling edge.
  task automatic cyc(input logic [27:0] in, input bit chk, input logic [15:0] cnt);
    exp_t e;
    io_in = in;
    @(posedge clk);
    #1;
    if (chk) begin
      e.out = pads_for(cnt);
      e.cnt = cnt;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare on falling edges whenever an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("io_out@cnt=%h", e.cnt), io_out, e.out);
      check("io_oeb", io_oeb, 28'h0000003);
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    io_in  = 28'h0;
    #1;
    // Asynchronous clear visible before any clock edge.
    io_in = 28'h3;
    #1;
    check("reset_async_out", io_out, 28'h0000000);
    check("reset_async_oeb", io_oeb, 28'h0000003);

    // Reset held with en=1: reset has priority, counter stays 0.
    for (int i = 0; i < 5; i++) cyc(28'h3, 1'b1, 16'h0000);

    // Count 1..100.
    for (int i = 1; i <= 100; i++) cyc(28'h2, 1'b1, 16'(i));

    // Hold at 100 for 7 cycles, then resume.
    for (int i = 0; i < 7; i++) cyc(28'h0, 1'b1, 16'd100);
    cyc(28'h2, 1'b1, 16'd101);

    // Unused input pads must be ignored.
    cyc(28'hFFFFFF2, 1'b1, 16'd102);

    // Run to 0x1234.
    for (int i = 103; i <= 16'h1234; i++) cyc(28'h2, (i == 16'h1234), 16'(i));

    // Mid-run 3 ns reset pulse in the low half of the clock.
    @(negedge clk);
    #1;
    io_in = 28'h3;
    #1;
    check("midrun_reset_async", io_out, 28'h0000000);
    #2;
    io_in = 28'h2;
    cyc(28'h2, 1'b1, 16'd1);

    // Count to 10, hold 7 cycles, resume to 11.
    for (int i = 2; i <= 10; i++) cyc(28'h2, 1'b1, 16'(i));
    for (int i = 0; i < 7; i++) cyc(28'h0, 1'b1, 16'd10);
    cyc(28'h2, 1'b1, 16'd11);

    // Long run up to 0xFFFE, checking only the last value.
    for (int i = 12; i <= 16'hFFFE; i++) cyc(28'h2, (i == 16'hFFFE), 16'(i));

    // Terminal count, held terminal count, wrap, and restart.
    cyc(28'h2, 1'b1, 16'hFFFF);
    cyc(28'h0, 1'b1, 16'hFFFF);
    cyc(28'h2, 1'b1, 16'h0000);
    cyc(28'h0, 1'b1, 16'h0000);
    cyc(28'h2, 1'b1, 16'h0001);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
